shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares a single WIDTH-bit D-flip-flop storage register among N_REQ requesters. Each requester raises a level request with its write data. The block grants one requester at a time, captures that requester's data into the register, and then holds the register locked for a configurable number of cycles before it arbitrates again. It sits between the requesting blocks and the shared flop bank, and provides the only write path into that bank.

## Interface
- WIDTH, 8, width of the shared register and of each data slice
- N_REQ, 4, number of requesters (2..16)
- HOLD_CYC, 2, lock cycles after each write (0..255)
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req  input  N_REQ  level request; bit i belongs to requester i
- wdata  input  N_REQ*WIDTH  write data; slice i is bits [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  registered one-hot grant; high for exactly one cycle per write
- q  output  WIDTH  shared register contents
- owner  output  clog2(N_REQ)  index of the last requester written
- busy  output  1  high whenever the state is not IDLE (registered)

## Operation
- The FSM has three states: IDLE, WRITE and HOLD.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise, select the winner: search from the pointer ptr upward, modulo N_REQ. The first set req bit wins.
  - On that edge: gnt <= onehot(winner), latch the winner index, ptr <= (winner+1) mod N_REQ, state -> WRITE.
- WRITE (exactly 1 cycle):
  - The winner must hold its wdata slice stable while gnt is high.
  - At the edge that ends WRITE: q <= wdata[winner slice], owner <= winner, gnt <= 0.
  - Next state is HOLD if HOLD_CYC > 0, otherwise IDLE.
- HOLD:
  - The counter loads HOLD_CYC-1 on entry and decrements each cycle.
  - When the counter is 0, state -> IDLE.
  - req is ignored in HOLD.
- Arbitration happens only in IDLE. Every grant is preceded by at least one IDLE cycle.
- A requester must drive req low in the cycle after its gnt. A req bit still high when IDLE samples it counts as a new request.
- A req pulse that rises and falls entirely inside WRITE or HOLD is lost. The block does not store pending requests.
- Requests may change at any time. Only the value present at the sampling IDLE edge matters.
- q changes only at the end of WRITE. No other path writes q.

## Timing
- Reset values: q=0, gnt=0, owner=0, busy=0, ptr=0, hold counter=0, state=IDLE.
- Reset acts immediately on assertion, including mid-WRITE or mid-HOLD. An in-flight write is abandoned and q is not updated.
- Grant latency: req high at IDLE edge e0 -> gnt high in cycle e0..e1 -> q valid after e1.
- busy is high from e0 to e1+HOLD_CYC. busy is low in IDLE.
- Minimum spacing between grants is 2+HOLD_CYC cycles (IDLE + WRITE + HOLD_CYC).
- Pointer wrap: a win by requester N_REQ-1 sets ptr=0.
- Priority after a grant to requester k is k+1, k+2, ..., k, modulo N_REQ. This gives starvation-free service: with all requests held, each requester waits at most N_REQ grants.
- gnt is never multi-hot and is never high outside WRITE.

## Test plan
- Reset mid-operation: WIDTH=8, N_REQ=4, HOLD_CYC=2, req=4'b0001, wdata slice0=8'h3C. Assert rst during the gnt cycle -> gnt=0 and busy=0 immediately. q stays 8'h00. After release, the next grant still goes to requester 0.
- Single request: req=4'b0010, slice1=8'hA5 -> gnt=4'b0010 one cycle after the sampling edge. Next edge: q=8'hA5, owner=1. busy is high for 3 cycles.
- Fairness: req=4'b1111 held continuously, HOLD_CYC=2 -> grant order 0,1,2,3,0,1, with exactly 4 cycles between consecutive gnt pulses.
- Wrap: grant to requester 3, then req=4'b1001 -> next grant is 0, the following grant is 3. q takes each winner's slice in turn.
- HOLD_CYC=0: req=4'b0101 held -> grants alternate 0,2,0 every 2 cycles. busy high exactly during WRITE.
- Lost and late requests: pulse req[2] high for 1 cycle inside HOLD -> no grant. Raise req[1] during HOLD and keep it high -> it is granted at the first IDLE edge.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared
// WIDTH-bit register, followed by a HOLD_CYC-cycle lock before re-arbitration.
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int N_REQ    = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam logic [7:0] HOLD_LOAD = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   cur;
    logic [7:0]      hold_cnt;

    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   ptr_next;
    logic [WIDTH-1:0] slice [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // Walk from ptr upward with wrap; the first set request wins.
    always_comb begin
        win_idx  = '0;
        win_vld  = 1'b0;
        scan_idx = ptr;
        for (int off = 0; off < N_REQ; off++) begin
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
        end
    end

    assign ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            cur      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            q        <= '0;
            owner    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        cur   <= win_idx;
                        ptr   <= ptr_next;
                        state <= WRITE;
                        busy  <= 1'b1;
                    end
                end
                WRITE: begin
                    q     <= slice[cur];
                    owner <= cur;
                    gnt   <= '0;
                    if (HOLD_CYC > 0) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    // Requests are deliberately not looked at while locked.
                    if (hold_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: one instance with HOLD_CYC=2 and one with HOLD_CYC=0.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_a, req_b;
    logic [31:0] wdata_a, wdata_b;
    logic [3:0]  gnt_a, gnt_b;
    logic [7:0]  q_a, q_b;
    logic [1:0]  owner_a, owner_b;
    logic        busy_a, busy_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .HOLD_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a),
        .gnt(gnt_a), .q(q_a), .owner(owner_a), .busy(busy_a)
    );

    shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .HOLD_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b),
        .gnt(gnt_b), .q(q_b), .owner(owner_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_a = '0; req_b = '0; wdata_a = '0; wdata_b = '0;
        step(); step();
        chk("rst_q", 32'(q_a), 32'h00);
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_owner", 32'(owner_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        rst = 1'b0;

        // Reset during the grant cycle abandons the write.
        req_a = 4'b0001; wdata_a = 32'h0000_003C;
        step();
        chk("mid_gnt", 32'(gnt_a), 32'h1);
        req_a = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt_a), 32'h0);
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        chk("mid_rst_q", 32'(q_a), 32'h00);
        step();
        chk("mid_rst_q_hold", 32'(q_a), 32'h00);
        rst = 1'b0;
        req_a = 4'b0011; wdata_a = 32'h0000_553C;
        step();
        chk("post_rst_gnt", 32'(gnt_a), 32'h1);
        req_a = '0;
        step();
        chk("post_rst_q", 32'(q_a), 32'h3C);
        chk("post_rst_owner", 32'(owner_a), 32'h0);
        chk("post_rst_busy_w", 32'(busy_a), 32'h1);
        step();
        chk("post_rst_busy_h", 32'(busy_a), 32'h1);
        step();
        chk("post_rst_busy_i", 32'(busy_a), 32'h0);

        // Single request from requester 1.
        req_a = 4'b0010; wdata_a = 32'h0000_A500;
        step();
        chk("single_gnt", 32'(gnt_a), 32'h2);
        chk("single_busy0", 32'(busy_a), 32'h1);
        chk("single_q_pre", 32'(q_a), 32'h3C);
        req_a = '0;
        step();
        chk("single_gnt_off", 32'(gnt_a), 32'h0);
        chk("single_q", 32'(q_a), 32'hA5);
        chk("single_owner", 32'(owner_a), 32'h1);
        chk("single_busy1", 32'(busy_a), 32'h1);
        step();
        chk("single_busy2", 32'(busy_a), 32'h1);
        step();
        chk("single_busy3", 32'(busy_a), 32'h0);

        // Fairness with all requests held, starting from a fresh pointer.
        rst = 1'b1; step(); rst = 1'b0;
        req_a = 4'b1111; wdata_a = 32'h4433_2211;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k % 4 == 1)
                chk($sformatf("fair_gnt_%0d", k), 32'(gnt_a), 32'(4'b0001 << ((k / 4) % 4)));
            else
                chk($sformatf("fair_idle_%0d", k), 32'(gnt_a), 32'h0);
            if (k % 4 == 2)
                chk($sformatf("fair_q_%0d", k), 32'(q_a), 32'(8'h11 * (((k / 4) % 4) + 1)));
        end
        req_a = '0;

        // Wrap: win by 3 then 0 then 3 (pointer is 2 here).
        req_a = 4'b1000; wdata_a = 32'hC300_000F;
        step();
        chk("wrap_gnt3", 32'(gnt_a), 32'h8);
        req_a = 4'b1001;
        step();
        chk("wrap_q3", 32'(q_a), 32'hC3);
        chk("wrap_owner3", 32'(owner_a), 32'h3);
        step(); step(); step();
        chk("wrap_gnt0", 32'(gnt_a), 32'h1);
        req_a = 4'b1000;
        step();
        chk("wrap_q0", 32'(q_a), 32'h0F);
        chk("wrap_owner0", 32'(owner_a), 32'h0);
        step(); step(); step();
        chk("wrap_gnt3b", 32'(gnt_a), 32'h8);
        req_a = '0;
        step();
        chk("wrap_q3b", 32'(q_a), 32'hC3);
        step(); step();

        // Lost pulse inside HOLD, then late request held through HOLD (ptr=0).
        req_a = 4'b0001; wdata_a = 32'h0000_005A;
        step();
        chk("lost_gnt0", 32'(gnt_a), 32'h1);
        req_a = '0;
        step();
        req_a = 4'b0100;
        step();
        chk("lost_hold_gnt", 32'(gnt_a), 32'h0);
        req_a = '0;
        step();
        step();
        chk("lost_no_gnt", 32'(gnt_a), 32'h0);
        chk("lost_no_busy", 32'(busy_a), 32'h0);
        req_a = 4'b0001;
        step();
        chk("late_gnt0", 32'(gnt_a), 32'h1);
        req_a = '0;
        step();
        req_a = 4'b0010; wdata_a = 32'h0000_775A;
        step(); step();
        chk("late_pre_gnt", 32'(gnt_a), 32'h0);
        step();
        chk("late_gnt1", 32'(gnt_a), 32'h2);
        req_a = '0;
        step();
        chk("late_q", 32'(q_a), 32'h77);
        chk("late_owner", 32'(owner_a), 32'h1);

        // HOLD_CYC=0 instance: 0,2,0 every two cycles.
        req_b = 4'b0101; wdata_b = 32'h0020_0010;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k % 2 == 1) begin
                chk($sformatf("h0_gnt_%0d", k), 32'(gnt_b), (k == 3) ? 32'h4 : 32'h1);
                chk($sformatf("h0_busy_%0d", k), 32'(busy_b), 32'h1);
            end else begin
                chk($sformatf("h0_gnt_%0d", k), 32'(gnt_b), 32'h0);
                chk($sformatf("h0_busy_%0d", k), 32'(busy_b), 32'h0);
                chk($sformatf("h0_q_%0d", k), 32'(q_b), (k == 4) ? 32'h20 : 32'h10);
            end
        end
        req_b = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
